// File: rtl/ofdm_dec.sv
// 128-point single-symbol OFDM back end: 25-bin DFT accumulate (24 data + pilot 55), 2-bit amplitude slice vs pilot.
// Latency: PushOut 26 cycles after sample 127; no backpressure, Pushin outside IDLE/ACC is dropped.
// Optional OFDMDEC_CPLX_IN_EN enables complex input (DinI); default build treats DinI as 0.
module ofdm_dec (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Pushin,
    input  logic               FirstData,
    input  logic signed [16:0] DinR,
    input  logic signed [16:0] DinI,
    output logic               PushOut,
    output logic [47:0]        DataOut
);
    localparam int NBIN  = 25;
    localparam int PILOT = 24;

    typedef enum logic [1:0] {IDLE, ACC, DECIDE, OUT} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [6:0]         r_n;
    logic [4:0]         r_dcnt;
    logic [53:0]        r_pp;
    logic [47:0]        r_codes;

    logic               w_start;
    logic               w_acc_en;
    logic [6:0]         w_n;
    logic signed [26:0] w_re27 [NBIN];
    logic signed [26:0] w_im27 [NBIN];

    // Quarter-wave cosine table, Q1.15 rounded, folded by symmetry to the full 128 points.
    function automatic logic signed [16:0] f_cos(input logic [6:0] m);
        logic [5:0]  q;
        logic        neg;
        logic [15:0] mag;
        if (m <= 7'd32) begin
            q = m[5:0]; neg = 1'b0;
        end else if (m <= 7'd64) begin
            q = 6'(7'd64 - m); neg = 1'b1;
        end else if (m <= 7'd96) begin
            q = 6'(m - 7'd64); neg = 1'b1;
        end else begin
            q = 6'(8'd128 - {1'b0, m}); neg = 1'b0;
        end
        case (q)
            6'd0:  mag = 16'd32767;
            6'd1:  mag = 16'd32729;
            6'd2:  mag = 16'd32610;
            6'd3:  mag = 16'd32413;
            6'd4:  mag = 16'd32138;
            6'd5:  mag = 16'd31786;
            6'd6:  mag = 16'd31357;
            6'd7:  mag = 16'd30853;
            6'd8:  mag = 16'd30274;
            6'd9:  mag = 16'd29622;
            6'd10: mag = 16'd28899;
            6'd11: mag = 16'd28106;
            6'd12: mag = 16'd27246;
            6'd13: mag = 16'd26320;
            6'd14: mag = 16'd25330;
            6'd15: mag = 16'd24279;
            6'd16: mag = 16'd23170;
            6'd17: mag = 16'd22006;
            6'd18: mag = 16'd20788;
            6'd19: mag = 16'd19520;
            6'd20: mag = 16'd18205;
            6'd21: mag = 16'd16846;
            6'd22: mag = 16'd15447;
            6'd23: mag = 16'd14010;
            6'd24: mag = 16'd12540;
            6'd25: mag = 16'd11039;
            6'd26: mag = 16'd9512;
            6'd27: mag = 16'd7962;
            6'd28: mag = 16'd6393;
            6'd29: mag = 16'd4808;
            6'd30: mag = 16'd3212;
            6'd31: mag = 16'd1608;
            default: mag = 16'd0;
        endcase
        return neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_acc_en    = 1'b0;
        case (r_state)
            IDLE: begin
                if (Pushin && FirstData) begin
                    w_start     = 1'b1;
                    w_acc_en    = 1'b1;
                    w_state_nxt = ACC;
                end
            end
            ACC: begin
                if (Pushin) begin
                    w_acc_en = 1'b1;
                    if (FirstData)           w_start     = 1'b1;
                    else if (r_n == 7'd127)  w_state_nxt = DECIDE;
                end
            end
            DECIDE:  if (r_dcnt == 5'd24) w_state_nxt = OUT;
            OUT:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // A restart always processes the incoming sample as n=0 on cleared accumulators.
    assign w_n = w_start ? 7'd0 : r_n;

`ifndef OFDMDEC_CPLX_IN_EN
    logic w_unused_dini;
    assign w_unused_dini = ^DinI;
`endif

    for (genvar b = 0; b < NBIN; b++) begin : g_bin
        localparam logic [6:0] K = (b == PILOT) ? 7'd55 : 7'(4 + 2 * b);

        logic [6:0]         w_idx;
        logic signed [16:0] w_cos;
        logic signed [16:0] w_sin;
        logic signed [41:0] w_re_base;
        logic signed [41:0] w_im_base;
        logic signed [41:0] w_re_add;
        logic signed [41:0] w_im_add;
        logic signed [41:0] r_re;
        logic signed [41:0] r_im;

        assign w_idx     = K * w_n;
        assign w_cos     = f_cos(w_idx);
        assign w_sin     = f_cos(w_idx - 7'd32);
        assign w_re_base = w_start ? '0 : r_re;
        assign w_im_base = w_start ? '0 : r_im;
`ifdef OFDMDEC_CPLX_IN_EN
        assign w_re_add  = 42'(DinR * w_cos) + 42'(DinI * w_sin);
        assign w_im_add  = 42'(DinI * w_cos) - 42'(DinR * w_sin);
`else
        assign w_re_add  = 42'(DinR * w_cos);
        assign w_im_add  = -42'(DinR * w_sin);
`endif

        always_ff @(posedge Clk) begin
            if (Reset) begin
                r_re <= '0;
                r_im <= '0;
            end else if (w_acc_en) begin
                r_re <= w_re_base + w_re_add;
                r_im <= w_im_base + w_im_add;
            end
        end

        assign w_re27[b] = 27'(r_re >>> 15);
        assign w_im27[b] = 27'(r_im >>> 15);
    end

    // One shared power unit: pilot in DECIDE cycle 0, then data bins 4..50 in order.
    logic [4:0]         w_sel;
    logic signed [26:0] w_sre;
    logic signed [26:0] w_sim;
    logic signed [53:0] w_re_sq;
    logic signed [53:0] w_im_sq;
    logic [53:0]        w_pow;
    logic [63:0]        w_d36;
    logic [63:0]        w_d4;
    logic [63:0]        w_pp;
    logic [63:0]        w_pp25;
    logic [1:0]         w_code;

    assign w_sel   = (r_dcnt == 5'd0) ? 5'(PILOT) : r_dcnt - 5'd1;
    assign w_sre   = w_re27[w_sel];
    assign w_sim   = w_im27[w_sel];
    assign w_re_sq = w_sre * w_sre;
    assign w_im_sq = w_sim * w_sim;
    assign w_pow   = w_re_sq + w_im_sq;
    assign w_d36   = {10'd0, w_pow} * 64'd36;
    assign w_d4    = {10'd0, w_pow} * 64'd4;
    assign w_pp    = {10'd0, r_pp};
    assign w_pp25  = w_pp * 64'd25;

    always_comb begin
        w_code = 2'd3;
        if (r_pp == '0)            w_code = 2'd0;
        else if (w_d36 < w_pp)     w_code = 2'd0;
        else if (w_d4 < w_pp)      w_code = 2'd1;
        else if (w_d36 < w_pp25)   w_code = 2'd2;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_n     <= '0;
            r_dcnt  <= '0;
            r_pp    <= '0;
            r_codes <= '0;
            PushOut <= 1'b0;
            DataOut <= '0;
        end else begin
            PushOut <= 1'b0;
            if (w_acc_en) r_n <= w_start ? 7'd1 : r_n + 7'd1;
            if (r_state == DECIDE) begin
                r_dcnt <= r_dcnt + 5'd1;
                if (r_dcnt == 5'd0) r_pp    <= w_pow;
                else                r_codes <= {w_code, r_codes[47:2]};
            end else begin
                r_dcnt <= '0;
            end
            if (r_state == OUT) begin
                DataOut <= r_codes;
                PushOut <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ofdm_dec.sv
// Directed bench for ofdm_dec: IFFT-built symbols with known 48-bit words, latency, gaps, resets, restarts.
module tb_ofdm_dec;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               pushin = 1'b0;
    logic               first = 1'b0;
    logic signed [16:0] dinr = '0;
    logic signed [16:0] dini = '0;
    logic               pushout;
    logic [47:0]        dataout;

    int n_checks = 0;
    int n_pass   = 0;
    int push_cnt = 0;
    int samp [128];

    ofdm_dec dut (
        .Clk       (clk),
        .Reset     (rst),
        .Pushin    (pushin),
        .FirstData (first),
        .DinR      (dinr),
        .DinI      (dini),
        .PushOut   (pushout),
        .DataOut   (dataout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (pushout === 1'b1) push_cnt++;

    // x[n] = 32768 * (2/128) * (sum a_k cos(2*pi*k*n/128) + cos(2*pi*55*n/128)), a_k = code/3
    task automatic build(input logic [47:0] word, input bit zero);
        real acc;
        real tp;
        tp = 6.283185307179586;
        for (int n = 0; n < 128; n++) begin
            acc = 0.0;
            if (!zero) begin
                for (int i = 0; i < 24; i++)
                    acc += (real'(word[2*i +: 2]) / 3.0) * $cos(tp * real'((4 + 2*i) * n) / 128.0);
                acc += $cos(tp * real'(55 * n) / 128.0);
            end
            samp[n] = int'(acc * 2.0 / 128.0 * 32768.0);
        end
    endtask

    task automatic send(input int n_samp, input int gap_at, input int gap_len);
        for (int n = 0; n < n_samp; n++) begin
            if (n == gap_at) begin
                repeat (gap_len) begin
                    @(negedge clk);
                    pushin = 1'b0; first = 1'b0;
                end
            end
            @(negedge clk);
            pushin = 1'b1;
            first  = (n == 0);
            dinr   = 17'(samp[n]);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        pushin = 1'b0; first = 1'b0; dinr = '0;
    endtask

    // Called at the negedge right after the edge that captured sample 127.
    task automatic wait_push(input logic [47:0] exp, input string name);
        int cnt;
        cnt = 0;
        n_checks++;
        if (pushout !== 1'b0) $display("FAIL %s early_push: PushOut=%b, want 0", name, pushout);
        else n_pass++;
        while (cnt < 130 && pushout !== 1'b1) begin
            @(negedge clk);
            cnt++;
        end
        n_checks++;
        if (cnt != 26) $display("FAIL %s latency: got %0d cycles, want 26", name, cnt);
        else n_pass++;
        n_checks++;
        if (dataout !== exp) $display("FAIL %s data: got %h, want %h", name, dataout, exp);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (pushout !== 1'b0) $display("FAIL %s pulse_width: PushOut=%b one cycle later, want 0", name, pushout);
        else n_pass++;
        n_checks++;
        if (dataout !== exp) $display("FAIL %s data_hold: got %h, want %h", name, dataout, exp);
        else n_pass++;
    endtask

    task automatic run_symbol(input logic [47:0] word, input bit zero, input int gap_at,
                              input int gap_len, input logic [47:0] exp, input string name);
        build(word, zero);
        send(128, gap_at, gap_len);
        idle();
        wait_push(exp, name);
    endtask

    task automatic test_reset();
        rst = 1'b1; pushin = 1'b1; first = 1'b1; dinr = 17'sd1000;
        repeat (3) @(negedge clk);
        n_checks++;
        if (pushout !== 1'b0) $display("FAIL reset_pushout: got %b, want 0", pushout);
        else n_pass++;
        n_checks++;
        if (dataout !== 48'h0) $display("FAIL reset_dataout: got %h, want 0", dataout);
        else n_pass++;
        rst = 1'b0; pushin = 1'b0; first = 1'b0; dinr = '0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (push_cnt != 0) $display("FAIL reset_no_push: got %0d pushes, want 0", push_cnt);
        else n_pass++;
    endtask

    task automatic test_basic();
        run_symbol(48'hE23456789F1B, 1'b0, -1, 0, 48'hE23456789F1B, "basic");
    endtask

    task automatic test_back_to_back();
        run_symbol(48'h000000000000, 1'b0, -1, 0, 48'h000000000000, "b2b_zero");
        run_symbol(48'hFFFFFFFFFFFF, 1'b0, -1, 0, 48'hFFFFFFFFFFFF, "b2b_ones");
        run_symbol(48'hA5A5A5A5A5A5, 1'b0, -1, 0, 48'hA5A5A5A5A5A5, "b2b_a5");
    endtask

    task automatic test_gap();
        run_symbol(48'h555555555555, 1'b0, 64, 10, 48'h555555555555, "gap");
    endtask

    task automatic test_zero_pilot();
        run_symbol(48'hFFFFFFFFFFFF, 1'b1, -1, 0, 48'h000000000000, "zero_pilot");
    endtask

    task automatic test_restart();
        int pc0;
        pc0 = push_cnt;
        build(48'hFFFFFFFFFFFF, 1'b0);
        send(50, -1, 0);
        run_symbol(48'h0F0F0F0F0F0F, 1'b0, -1, 0, 48'h0F0F0F0F0F0F, "restart");
        repeat (5) @(negedge clk);
        n_checks++;
        if (push_cnt - pc0 != 1) $display("FAIL restart_count: got %0d pushes, want 1", push_cnt - pc0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int pc0;
        pc0 = push_cnt;
        build(48'hFFFFFFFFFFFF, 1'b0);
        send(60, -1, 0);
        @(negedge clk);
        rst = 1'b1; pushin = 1'b1; first = 1'b0; dinr = 17'(samp[60]);
        @(negedge clk);
        rst = 1'b0; pushin = 1'b0; dinr = '0;
        repeat (40) @(negedge clk);
        n_checks++;
        if (push_cnt != pc0) $display("FAIL reset_mid_discard: got %0d pushes, want 0", push_cnt - pc0);
        else n_pass++;
        n_checks++;
        if (dataout !== 48'h0) $display("FAIL reset_mid_dataout: got %h, want 0", dataout);
        else n_pass++;
        run_symbol(48'h100000000001, 1'b0, -1, 0, 48'h100000000001, "after_reset");
        repeat (5) @(negedge clk);
        n_checks++;
        if (push_cnt - pc0 != 1) $display("FAIL reset_mid_count: got %0d pushes, want 1", push_cnt - pc0);
        else n_pass++;
    endtask

    task automatic test_no_first();
        int pc0;
        pc0 = push_cnt;
        build(48'hFFFFFFFFFFFF, 1'b0);
        for (int i = 0; i < 140; i++) begin
            @(negedge clk);
            pushin = 1'b1; first = 1'b0; dinr = 17'(samp[i % 128]);
        end
        idle();
        repeat (40) @(negedge clk);
        n_checks++;
        if (push_cnt != pc0) $display("FAIL no_first_push: got %0d pushes, want 0", push_cnt - pc0);
        else n_pass++;
        n_checks++;
        if (dataout !== 48'h100000000001) $display("FAIL no_first_hold: got %h, want 100000000001", dataout);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_gap();
        test_zero_pilot();
        test_restart();
        test_reset_mid();
        test_no_first();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ofdm_dec.md
# ofdm_dec

Single-symbol OFDM receiver back end. It accepts one 128-sample time-domain symbol in Q1.15 and correlates it against 25 frequency bins: 24 data bins plus one pilot. It slices each data bin's amplitude against the pilot into a 2-bit code and emits the resulting 48-bit word with a one-cycle push. It sits after sample capture/synchronisation and feeds the packet/word layer.

## Interface
- No parameters. Fixed: N=128 points, data bins 4,6,…,50 (24 bins), pilot bin 55.
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Pushin  input  1  sample valid; one sample accepted per cycle with Pushin=1.
- FirstData  input  1  qualifies the accepted sample as sample n=0 of a symbol; ignored when Pushin=0.
- DinR  input  17 signed  real sample, Q1.15 (1.0 = 32768).
- DinI  input  17 signed  imaginary sample, Q1.15; used only with OFDMDEC_CPLX_IN_EN.
- PushOut  output  1  one-cycle strobe, DataOut valid.
- DataOut  output  48  decoded word; bin 4 → [1:0], bin 6 → [3:2], …, bin 50 → [47:46].

## Operation
- States: IDLE, ACC, DECIDE, OUT.
- IDLE:
  - Pushin&FirstData: clear all accumulators, accumulate sample n=0, set n=1, go to ACC.
  - Pushin without FirstData: ignored.
- ACC:
  - Each accepted sample n is accumulated into all 25 bins k: Re[k] += x·cos(2πkn/128), Im[k] −= x·sin(2πkn/128).
  - Cycles with Pushin=0 are gaps; n holds.
  - Pushin&FirstData restarts the symbol: clear accumulators, n=1.
  - After n=127 is accepted, go to DECIDE.
- Twiddles: cos/sin from a 128-entry table indexed by (k·n) mod 128, 17-bit signed Q1.15, rounded to nearest. cos(0)=32767.
- Arithmetic:
  - Products are 34-bit; accumulators are 42-bit signed, no saturation.
  - At DECIDE entry each accumulator is arithmetically shifted right 15 to a 27-bit value. Nominal: amplitude a gives ≈32768·a.
- Power: P[k] = Re² + Im², 54-bit unsigned. Pilot power Pp is computed in DECIDE cycle 0.
- Slicing: one data bin per cycle, bins 4…50 in order, DECIDE cycles 1–24, comparisons 64-bit, with D = P[k]:
  - 36·D < Pp → code 0
  - else 4·D < Pp → code 1
  - else 36·D < 25·Pp → code 2
  - else code 3
  - Pilot reference levels are 0, 1/3, 2/3, 1 of pilot amplitude. Thresholds sit at the midpoints.
- Pp = 0 → all codes 0.
- OUT: load DataOut, assert PushOut for exactly one cycle, return to IDLE. DataOut holds until the next result.
- Pushin during DECIDE/OUT is ignored, including FirstData. The next symbol must start after PushOut.

## Timing
- Reset: PushOut=0, DataOut=0, state IDLE, n=0, accumulators cleared. Reset wins over all simultaneous inputs. Reset mid-symbol or mid-DECIDE discards the symbol, and no PushOut follows.
- Latency: let edge E capture sample 127.
  - DECIDE occupies edges E+1…E+25.
  - Edge E+26 registers DataOut and PushOut=1.
  - Edge E+27 returns PushOut to 0.
- A gapless symbol therefore yields PushOut 26 cycles after the last Pushin cycle, well inside a 130-cycle window.
- Throughput: one symbol per ≥155 cycles.

## Configuration
- OFDMDEC_CPLX_IN_EN defined:
  - Full complex input.
  - Re[k] += xr·cos + xi·sin.
  - Im[k] += xi·cos − xr·sin.
- Undefined:
  - DinI is ignored and treated as 0, which halves the multipliers.
  - Bit-identical results for inputs with DinI=0.

## Test plan
- Real symbol synthesised by 128-point IFFT of bins 4…50 with amplitudes {0, 0.333, 0.666, 1.0} from 48'hE23456789F1B, conjugate-mirrored, pilot 1.0 at bins 55/73, scaled /128 then ×32768 → DataOut=48'hE23456789F1B, PushOut single pulse 26 cycles after last sample.
- Same construction with data 48'h000000000000, 48'hFFFFFFFFFFFF, 48'hA5A5A5A5A5A5 → exact match each, back-to-back symbols separated by ≥1 idle cycle.
- 48'h555555555555 sent with 10 Pushin=0 gap cycles inserted mid-symbol → DataOut=48'h555555555555, PushOut 26 cycles after final sample.
- All-zero samples (pilot power 0) → DataOut=0, PushOut pulses.
- Reset asserted at sample 60, then full symbol 48'h100000000001 → exactly one PushOut, DataOut=48'h100000000001. Pushin without FirstData while IDLE → no PushOut.
